// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode / memory-state types and decode helpers for the LC-3
// pipeline sequencer and its bypass unit.
package lc3_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    MEM_READ     = 2'd0,
    MEM_INDIRECT = 2'd1,
    MEM_WRITE    = 2'd2,
    MEM_IDLE     = 2'd3
  } mem_state_t;

  // Result produced by the execute stage's ALU path.
  function automatic logic is_alu(input opcode_t op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  endfunction

  // Result arrives from data memory.
  function automatic logic is_load(input opcode_t op);
    return op inside {OP_LD, OP_LDR, OP_LDI};
  endfunction

  function automatic logic is_store(input opcode_t op);
    return op inside {OP_ST, OP_STR, OP_STI};
  endfunction

  // Instructions that redirect fetch and therefore stall it.
  function automatic logic is_ctrl(input opcode_t op);
    return op inside {OP_BR, OP_JMP};
  endfunction

  // IR[8:6] is a register source.
  function automatic logic uses_src1(input opcode_t op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP};
  endfunction

  // IR[2:0] is a register source (register form of ADD/AND only).
  function automatic logic uses_src2(input opcode_t op, input logic imm_flag);
    return (op inside {OP_ADD, OP_AND}) && !imm_flag;
  endfunction

  // First memory state an instruction enters when it leaves execute.
  function automatic mem_state_t mem_entry(input opcode_t op);
    case (op)
      OP_LD, OP_LDR:  return MEM_READ;
      OP_ST, OP_STR:  return MEM_WRITE;
      OP_LDI, OP_STI: return MEM_INDIRECT;
      // NOTE: the default arm makes every path return a value, so no
      // latch or X can leak out of this decode.
      default:        return MEM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lc3_bypass_unit.sv
// Operand-forwarding selects: compares the execute-stage destination with
// the sources of the instruction entering execute.
module lc3_bypass_unit
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] i_ir,
  input  logic [15:0] i_ir_exec,
  input  logic        i_v_ex,
  input  logic        i_v_wb,
  output logic        o_bypass_alu_1,
  output logic        o_bypass_alu_2,
  output logic        o_bypass_mem_1,
  output logic        o_bypass_mem_2
);

  opcode_t    w_op;
  opcode_t    w_op_exec;
  logic [2:0] w_dest;
  logic       w_live;
  logic       w_hit_1;
  logic       w_hit_2;
  logic       w_unused;

  assign w_op      = opcode_t'(i_ir[15:12]);
  assign w_op_exec = opcode_t'(i_ir_exec[15:12]);
  assign w_dest    = i_ir_exec[11:9];

  // Forwarding only makes sense when both downstream stages hold real work.
  assign w_live  = i_v_ex & i_v_wb;
  assign w_hit_1 = w_live & uses_src1(w_op) & (i_ir[8:6] == w_dest);
  assign w_hit_2 = w_live & uses_src2(w_op, i_ir[5]) & (i_ir[2:0] == w_dest);

  // ALU and load classes are disjoint, so alu_n and mem_n never coincide.
  assign o_bypass_alu_1 = w_hit_1 & is_alu(w_op_exec);
  assign o_bypass_alu_2 = w_hit_2 & is_alu(w_op_exec);
  assign o_bypass_mem_1 = w_hit_1 & is_load(w_op_exec);
  assign o_bypass_mem_2 = w_hit_2 & is_load(w_op_exec);

  assign w_unused = ^{i_ir[11:9], i_ir[4:3], i_ir_exec[8:0]};

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC-3 pipeline sequencer: stage enables, memory-access freeze, branch
// stall/redirect strobe and operand-bypass selects. CTRL_STALL is the number
// of fetch-stall cycles after a BR/JMP decode and must lie in 2..7.
module lc3_pipe_ctrl
  import lc3_ctrl_pkg::*;
#(
  parameter int CTRL_STALL = 3
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] Instr_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);

  logic       r_v_dec;
  logic       r_v_ex;
  logic       r_v_wb;
  mem_state_t r_mem_state;
  logic       r_ind_store;
  logic [2:0] r_ctrl_cnt;
  logic [2:0] r_br_cc;
  logic       r_br_jmp;

  opcode_t    w_dec_op;
  opcode_t    w_ex_op;
  logic       w_mem_idle;
  logic       w_fetch_ok;
  logic       w_en_dec;
  logic       w_en_ex;
  logic       w_en_wb;
  logic       w_dec_ctrl;
  logic       w_br_taken;
  logic       w_byp_alu_1;
  logic       w_byp_alu_2;
  logic       w_byp_mem_1;
  logic       w_byp_mem_2;
  logic       w_unused;

  assign w_dec_op   = opcode_t'(Instr_dout[15:12]);
  assign w_ex_op    = opcode_t'(IR_Exec[15:12]);

  assign w_mem_idle = (r_mem_state == MEM_IDLE);
  assign w_fetch_ok = w_mem_idle & (r_ctrl_cnt == 3'd0) & complete_instr;
  assign w_en_dec   = w_mem_idle & r_v_dec;
  assign w_en_ex    = w_mem_idle & r_v_ex;
  assign w_en_wb    = w_mem_idle & r_v_wb;
  assign w_dec_ctrl = w_en_dec & is_ctrl(w_dec_op);
  assign w_br_taken = w_mem_idle & (r_ctrl_cnt == 3'd1) &
                      (r_br_jmp | (|(r_br_cc & NZP)));

  lc3_bypass_unit u_bypass (
    .i_ir           (IR),
    .i_ir_exec      (IR_Exec),
    .i_v_ex         (r_v_ex),
    .i_v_wb         (r_v_wb),
    .o_bypass_alu_1 (w_byp_alu_1),
    .o_bypass_alu_2 (w_byp_alu_2),
    .o_bypass_mem_1 (w_byp_mem_1),
    .o_bypass_mem_2 (w_byp_mem_2)
  );

  // Outputs read as their reset values during the reset cycle itself, so an
  // access or stall in flight is dropped immediately.
  assign enable_fetch     = w_fetch_ok  & ~reset;
  assign enable_updatePC  = w_fetch_ok  & ~reset;
  assign enable_decode    = w_en_dec    & ~reset;
  assign enable_execute   = w_en_ex     & ~reset;
  assign enable_writeback = w_en_wb     & ~reset;
  assign br_taken         = w_br_taken  & ~reset;
  assign bypass_alu_1     = w_byp_alu_1 & ~reset;
  assign bypass_alu_2     = w_byp_alu_2 & ~reset;
  assign bypass_mem_1     = w_byp_mem_1 & ~reset;
  assign bypass_mem_2     = w_byp_mem_2 & ~reset;
  assign mem_state        = reset ? MEM_IDLE : r_mem_state;

  // Stage-valid shift register; frozen whenever a data access is in flight.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments let every stage read the previous
    // cycle's value of its predecessor, giving a true one-cycle shift.
    if (reset) begin
      r_v_dec <= 1'b0;
      r_v_ex  <= 1'b0;
      r_v_wb  <= 1'b0;
    end else if (w_mem_idle) begin
      r_v_dec <= w_fetch_ok;
      r_v_ex  <= r_v_dec;
      r_v_wb  <= r_v_ex;
    end
  end

  // Control-flow stall counter and latched branch condition.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ctrl_cnt <= 3'd0;
      r_br_cc    <= 3'd0;
      r_br_jmp   <= 1'b0;
    end else if (w_dec_ctrl) begin
      r_ctrl_cnt <= 3'(CTRL_STALL);
      r_br_cc    <= Instr_dout[11:9];
      r_br_jmp   <= (w_dec_op == OP_JMP);
    end else if (w_mem_idle && (r_ctrl_cnt != 3'd0)) begin
      r_ctrl_cnt <= r_ctrl_cnt - 3'd1;
    end
  end

  // Data-memory FSM: entered from execute, advanced only by complete_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_state <= MEM_IDLE;
      r_ind_store <= 1'b0;
    end else begin
      case (r_mem_state)
        MEM_IDLE: begin
          if (w_en_ex) begin
            r_mem_state <= mem_entry(w_ex_op);
            r_ind_store <= is_store(w_ex_op);
          end
        end
        MEM_INDIRECT: begin
          if (complete_data) begin
            r_mem_state <= r_ind_store ? MEM_WRITE : MEM_READ;
          end
        end
        MEM_READ, MEM_WRITE: begin
          if (complete_data) begin
            r_mem_state <= MEM_IDLE;
          end
        end
      endcase
    end
  end

  assign w_unused = ^Instr_dout[8:0];

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl: a cycle model built from stage
// occupancy, a stall countdown and a queue of pending memory phases is
// compared with the DUT every cycle; literal checks pin the model.
module tb_lc3_pipe_ctrl;

  localparam int          STALL   = 3;
  localparam logic [15:0] NOP     = 16'h0000;
  localparam logic [15:0] ADD_IMM = 16'h1262; // ADD R1,R1,#2
  localparam logic [15:0] ADD_R3  = 16'h1661; // ADD R3,R1,#1
  localparam logic [15:0] ADD_RR  = 16'h12C3; // ADD R1,R3,R3
  localparam logic [15:0] LDR_R3  = 16'h6680; // LDR R3,R2,#0
  localparam logic [15:0] LDI_R0  = 16'hA000;
  localparam logic [15:0] STI_R0  = 16'hB000;
  localparam logic [15:0] ST_R0   = 16'h3000;
  localparam logic [15:0] BR_N    = 16'h0802;
  localparam logic [15:0] BR_NZP  = 16'h0E02;
  localparam logic [15:0] JMP_R2  = 16'hC080;

  logic        clock;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] Instr_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic        enable_updatePC, enable_fetch, enable_decode;
  logic        enable_execute, enable_writeback, br_taken;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0]  mem_state;

  logic [11:0] w_outs;
  logic [4:0]  w_ens;

  int n_tests = 0;
  int n_fail  = 0;

  lc3_pipe_ctrl #(.CTRL_STALL(STALL)) dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .Instr_dout       (Instr_dout),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .NZP              (NZP),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .bypass_mem_1     (bypass_mem_1),
    .bypass_mem_2     (bypass_mem_2),
    .mem_state        (mem_state)
  );

  assign w_ens  = {enable_fetch, enable_updatePC, enable_decode,
                   enable_execute, enable_writeback};
  assign w_outs = {w_ens, br_taken, bypass_alu_1, bypass_alu_2,
                   bypass_mem_1, bypass_mem_2, mem_state};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample point: just after the falling edge, well clear of the rising edge.
  task automatic look();
    @(negedge clock);
    #1;
  endtask

  // Inputs change just after the rising edge.
  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic set_defaults();
    complete_instr = 1'b1;
    complete_data  = 1'b0;
    Instr_dout     = ADD_IMM;
    IR             = NOP;
    IR_Exec        = NOP;
    NZP            = 3'b000;
  endtask

  // Two reset cycles; on return the first post-reset cycle (c1) has begun.
  task automatic do_reset();
    reset = 1'b1;
    set_defaults();
    look();
    check("rst_cycle_outs", 16'(w_outs), 16'h003);
    adv();
    look();
    check("rst_hold_outs", 16'(w_outs), 16'h003);
    adv();
    reset = 1'b0;
  endtask

  function automatic logic [3:0] model_bypass(input logic [15:0] ir,
                                              input logic [15:0] irx,
                                              input bit live);
    logic [3:0] op;
    logic [3:0] opx;
    bit s1, s2, alu, ld, h1, h2;
    op  = ir[15:12];
    opx = irx[15:12];
    s1  = op inside {4'd1, 4'd5, 4'd9, 4'd6, 4'd7, 4'd12};
    s2  = (op == 4'd1 || op == 4'd5) && !ir[5];
    alu = opx inside {4'd1, 4'd5, 4'd9, 4'd14};
    ld  = opx inside {4'd2, 4'd6, 4'd10};
    h1  = live && s1 && (ir[8:6] == irx[11:9]);
    h2  = live && s2 && (ir[2:0] == irx[11:9]);
    return {h1 && alu, h2 && alu, h1 && ld, h2 && ld};
  endfunction

  // Reference model: slot[k] holds the fetch serial in decode/execute/
  // writeback (-1 = bubble); mem_q lists the memory states still to visit.
  initial begin : model
    int slot[3];
    int stall;
    logic [2:0] cc;
    bit jmp;
    int mem_q[$];
    int serial;
    slot   = '{-1, -1, -1};
    stall  = 0;
    cc     = 3'b000;
    jmp    = 1'b0;
    serial = 0;
    forever begin
      bit idle, f, d, x, w, bt;
      int cur_ms;
      logic [3:0] byp;
      logic [11:0] exp;
      @(negedge clock);
      idle   = (mem_q.size() == 0);
      cur_ms = idle ? 3 : mem_q[0];
      f      = idle && (stall == 0) && complete_instr;
      d      = idle && (slot[0] >= 0);
      x      = idle && (slot[1] >= 0);
      w      = idle && (slot[2] >= 0);
      bt     = idle && (stall == 1) && (jmp || ((cc & NZP) != 3'b000));
      byp    = model_bypass(IR, IR_Exec, (slot[1] >= 0) && (slot[2] >= 0));
      if (reset) exp = 12'h003;
      else       exp = {f, f, d, x, w, bt, byp, 2'(cur_ms)};
      check("cycle_outs", 16'(w_outs), 16'(exp));

      if (reset) begin
        slot  = '{-1, -1, -1};
        stall = 0;
        cc    = 3'b000;
        jmp   = 1'b0;
        mem_q.delete();
      end else begin
        if (d && (Instr_dout[15:12] == 4'd0 || Instr_dout[15:12] == 4'd12)) begin
          stall = STALL;
          cc    = Instr_dout[11:9];
          jmp   = (Instr_dout[15:12] == 4'd12);
        end else if (idle && stall > 0) begin
          stall--;
        end
        if (idle) begin
          if (x) begin
            case (IR_Exec[15:12])
              4'd2, 4'd6: mem_q.push_back(0);
              4'd3, 4'd7: mem_q.push_back(2);
              4'd10:      begin mem_q.push_back(1); mem_q.push_back(0); end
              4'd11:      begin mem_q.push_back(1); mem_q.push_back(2); end
              default:    ;
            endcase
          end
          slot[2] = slot[1];
          slot[1] = slot[0];
          slot[0] = f ? serial : -1;
          if (f) serial++;
        end else if (complete_data) begin
          void'(mem_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    int fcount;
    int dcount;
    reset = 1'b1;
    set_defaults();

    // A: pipeline fill, ALU/load bypass, single-read freeze.
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      case (c)
        5: begin IR_Exec = ADD_R3; IR = ADD_RR; end
        6: IR_Exec = LDR_R3;
        7: begin IR_Exec = NOP; IR = NOP; complete_data = 1'b1; end
        8: complete_data = 1'b0;
        default: ;
      endcase
      look();
      case (c)
        1: begin
          check("fill_c1_fetch", 16'(enable_fetch), 16'd1);
          check("fill_c1_upd", 16'(enable_updatePC), 16'd1);
          check("fill_c1_dec", 16'(enable_decode), 16'd0);
          check("fill_c1_ms", 16'(mem_state), 16'd3);
        end
        2: check("fill_c2_dec_ex", 16'({enable_decode, enable_execute}), 16'b10);
        3: check("fill_c3_ex_wb", 16'({enable_execute, enable_writeback}), 16'b10);
        4: check("fill_c4_wb", 16'(enable_writeback), 16'd1);
        5: check("byp_alu", 16'({bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2}), 16'b1100);
        6: check("byp_mem", 16'({bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2}), 16'b0011);
        7: check("ldr_ms_read", 16'({mem_state, w_ens}), 16'({2'd0, 5'b00000}));
        8: check("ldr_ms_done", 16'({mem_state, enable_fetch}), 16'({2'd3, 1'b1}));
        default: ;
      endcase
      adv();
    end

    // B: BR taken, BR not taken, JMP.
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      case (c)
        3:  begin Instr_dout = BR_N; NZP = 3'b100; end
        8:  begin Instr_dout = BR_N; NZP = 3'b010; end
        13: begin Instr_dout = JMP_R2; NZP = 3'b000; end
        default: Instr_dout = ADD_IMM;
      endcase
      look();
      case (c)
        3:  check("br_dec", 16'(enable_decode), 16'd1);
        4:  check("br_c4_fetch_bt", 16'({enable_fetch, br_taken}), 16'b00);
        5:  check("br_c5_bubble", 16'({enable_fetch, enable_decode}), 16'b00);
        6:  check("br_c6_taken", 16'({enable_fetch, br_taken}), 16'b01);
        7:  check("br_c7_resume", 16'({enable_fetch, br_taken}), 16'b10);
        10: check("brnt_c10_fetch", 16'(enable_fetch), 16'd0);
        11: check("brnt_c11_bt", 16'({enable_fetch, br_taken}), 16'b00);
        12: check("brnt_c12_resume", 16'(enable_fetch), 16'd1);
        16: check("jmp_taken", 16'({enable_fetch, br_taken}), 16'b01);
        17: check("jmp_resume", 16'(enable_fetch), 16'd1);
        default: ;
      endcase
      adv();
    end

    // C: LDI and STI through INDIRECT; complete_data ignored when idle.
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      case (c)
        3:  IR_Exec = LDI_R0;
        10: IR_Exec = STI_R0;
        default: IR_Exec = NOP;
      endcase
      complete_data = (c == 5 || c == 7 || c == 9 || c == 11 || c == 12);
      look();
      case (c)
        3:  check("ldi_c3_ms", 16'(mem_state), 16'd3);
        4:  check("ldi_c4_ind", 16'({mem_state, w_ens}), 16'({2'd1, 5'b00000}));
        5:  check("ldi_c5_ind", 16'(mem_state), 16'd1);
        6:  check("ldi_c6_read", 16'({mem_state, w_ens}), 16'({2'd0, 5'b00000}));
        7:  check("ldi_c7_read", 16'(mem_state), 16'd0);
        8:  check("ldi_c8_resume", 16'({mem_state, w_ens}), 16'({2'd3, 5'b11111}));
        10: check("idle_cd_ignored", 16'(mem_state), 16'd3);
        11: check("sti_ind", 16'(mem_state), 16'd1);
        12: check("sti_write", 16'(mem_state), 16'd2);
        13: check("sti_done", 16'(mem_state), 16'd3);
        default: ;
      endcase
      adv();
    end

    // D: memory entry and BR decode together, then reset mid-write/mid-stall.
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      Instr_dout    = (c == 3) ? BR_NZP : ADD_IMM;
      IR_Exec       = (c == 3 || c == 5) ? ST_R0 : NOP;
      complete_data = (c == 4);
      look();
      case (c)
        3: check("both_dec_ex", 16'({enable_decode, enable_execute}), 16'b11);
        4: check("both_c4_write", 16'({mem_state, enable_fetch, enable_decode}), 16'({2'd2, 2'b00}));
        5: check("both_c5_stall", 16'({mem_state, enable_fetch, enable_execute}), 16'({2'd3, 2'b01}));
        6: check("both_c6_write", 16'({mem_state, enable_fetch}), 16'({2'd2, 1'b0}));
        7: check("both_c7_write", 16'(mem_state), 16'd2);
        default: ;
      endcase
      adv();
    end
    do_reset();
    look();
    check("post_abort_fetch", 16'({mem_state, enable_fetch, br_taken}), 16'({2'd3, 2'b10}));
    adv();

    // E: complete_instr gap of three cycles.
    do_reset();
    fcount = 0;
    dcount = 0;
    for (int c = 1; c <= 12; c++) begin
      complete_instr = !(c >= 5 && c <= 7);
      look();
      if (c <= 11) fcount += int'(enable_fetch);
      if (c >= 2)  dcount += int'(enable_decode);
      case (c)
        5: check("gap_c5", 16'({enable_fetch, enable_decode}), 16'b01);
        6: check("gap_c6", 16'({enable_fetch, enable_decode}), 16'b00);
        8: check("gap_c8", 16'({enable_fetch, enable_decode}), 16'b10);
        9: check("gap_c9", 16'(enable_decode), 16'd1);
        default: ;
      endcase
      adv();
    end
    check("gap_fetch_count", 16'(fcount), 16'd8);
    check("gap_decode_count", 16'(dcount), 16'd8);

    look();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_ctrl.md
Name: lc3_pipe_ctrl

Overview:
Pipeline sequencer for the LC-3 core. Generates the stage enables (fetch, updatePC, decode, execute, writeback), freezes the pipeline during data-memory access and after control-flow instructions, and produces the branch-taken and operand-bypass selects. The decode stage consumes enable_decode from this block; the block observes Instr_dout, the decoded IR, IR_Exec and NZP.

Parameters:
CTRL_STALL, 3, fetch-stall cycles after a BR/JMP is decoded (legal range 2..7).

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high
complete_instr  input  1  instruction memory holds a valid word this cycle
complete_data  input  1  data memory access finished this cycle
Instr_dout  input  16  instruction presented to decode
IR  input  16  instruction latched by decode (entering execute)
IR_Exec  input  16  instruction latched by execute
NZP  input  3  condition codes from writeback
enable_updatePC  output  1  PC advance
enable_fetch  output  1  fetch enable
enable_decode  output  1  decode enable
enable_execute  output  1  execute enable
enable_writeback  output  1  writeback enable
br_taken  output  1  one-cycle redirect strobe
bypass_alu_1, bypass_alu_2  output  1 each  forward ALU result to src1/src2
bypass_mem_1, bypass_mem_2  output  1 each  forward load data to src1/src2
mem_state  output  2  READ=0, INDIRECT=1, WRITE=2, IDLE=3

Behaviour:
- State regs: v_dec, v_ex, v_wb (stage valid), mem_state, ctrl_cnt (3b), br_cc (3b), br_jmp.
- Reset (sync): v_* = 0, ctrl_cnt = 0, mem_state = IDLE, br_cc = 0, br_jmp = 0. Outputs in the reset cycle: enables 0, br_taken 0, bypass 0, mem_state 3. Reset mid-access or mid-stall aborts immediately.
- mem_idle = (mem_state == IDLE).
- fetch_ok = mem_idle & ctrl_cnt == 0 & complete_instr. The two fetch outputs are defined as follows:
  - enable_fetch = fetch_ok.
  - enable_updatePC = fetch_ok.
- enable_decode = mem_idle & v_dec. enable_execute = mem_idle & v_ex. enable_writeback = mem_idle & v_wb.
- On each mem_idle cycle: v_dec <= fetch_ok, v_ex <= v_dec, v_wb <= v_ex. Otherwise all v_* hold (pipeline frozen).
- First enable_decode appears 1 cycle after the first fetch, execute after 2, writeback after 3.
- Control flow: enable_decode high with Instr_dout[15:12] in {BR=0000, JMP=1100} does the following:
  - ctrl_cnt <= CTRL_STALL.
  - br_cc <= Instr_dout[11:9].
  - br_jmp <= (opcode == JMP).
  - ctrl_cnt decrements on mem_idle cycles while nonzero.
- br_taken = mem_idle & ctrl_cnt == 1 & (br_jmp | |(br_cc & NZP)). It is high for exactly one cycle; fetch resumes the next cycle.
- Memory FSM: a cycle with enable_execute high and IR_Exec opcode in the set below moves mem_state as follows on the next edge:
  - LD(0010) or LDR(0110) -> READ.
  - ST(0011) or STR(0111) -> WRITE.
  - LDI(1010) or STI(1011) -> INDIRECT.
- Memory FSM progress happens only on complete_data:
  - INDIRECT -> READ (LDI) or WRITE (STI); the op is held in an internal 1-bit register.
  - READ -> IDLE.
  - WRITE -> IDLE.
  - complete_data in IDLE is ignored.
- Simultaneous events: a memory op entering and a BR decode in the same cycle both take effect. ctrl_cnt does not decrement while the memory FSM is busy.
- Bypass logic is combinational and gated by v_ex & v_wb.
  - src1 = IR[8:6] for ADD/AND/NOT/LDR/STR/JMP.
  - src2 = IR[2:0] for ADD/AND with IR[5] == 0.
  - dest = IR_Exec[11:9].
  - bypass_alu_n = dest matches src_n & IR_Exec in {ADD, AND, NOT, LEA}.
  - bypass_mem_n = dest matches src_n & IR_Exec in {LD, LDR, LDI}.
  - alu_n and mem_n are never both high.

Decomposition:
- lc3_ctrl_pkg holds the following:
  - opcode enum (4b).
  - mem_state_t enum with the encodings above.
  - functions is_alu, is_load, is_store, is_ctrl, uses_src1, uses_src2.
- One sub-module, lc3_bypass_unit: purely combinational, inputs IR, IR_Exec, v_ex, v_wb; outputs the four bypass bits.

Test Plan:
- Reset, then complete_instr = 1 with an ADD stream -> fetch = 1 from cycle 1; decode/execute/writeback first high at cycles 2/3/4; mem_state = 3.
- BR n (0000_100_...) decoded with NZP = 3'b100 -> fetch low 3 cycles; br_taken = 1 on the 3rd; fetch resumes on the 4th. With NZP = 3'b010 -> br_taken = 0, same stall.
- LDI in execute, complete_data pulses after 2 and 4 cycles -> mem_state 1 -> 0 -> 3; all enables 0 throughout; pipeline resumes the cycle after IDLE.
- IR_Exec = ADD R3, IR = ADD R1, R3, R3 (IR[5] = 0) -> bypass_alu_1 = bypass_alu_2 = 1. With IR_Exec = LDR R3 instead -> bypass_mem_1/2 = 1 and alu bits 0.
- Reset asserted while mem_state = WRITE and ctrl_cnt = 2 -> next cycle all outputs at reset values and mem_state = 3.
- complete_instr = 0 for 3 cycles mid-stream -> fetch = 0; bubbles propagate (decode low 1 cycle later for 3 cycles); no instruction duplicated.
